mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Moore FSM that sequences the multicycle MIPS datapath: fetch, decode, execute, memory and writeback.
- Sits beside the datapath and drives every mux select and write enable from state plus opcode.
- `op` is IR[31:26], taken from the instruction register. It is stable from DECODE until the instruction returns to FETCH.

Parameters:
- PC_INC_SEL, 2'b01: alusrcb value selecting the constant-4 PC increment in FETCH.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op  in  6  opcode from instruction register
- memready  in  1  memory done; present only with MEM_WAIT_EN
- pcwrite  out  1  unconditional PC load
- branch  out  1  PC load if ALU zero (BEQ)
- bne  out  1  PC load if ALU not zero (BNE)
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- irwrite  out  1  instruction register load
- memwrite  out  1  data memory write
- regwrite  out  1  register file write
- regdst  out  1  write register: 0 = rt, 1 = rd
- memtoreg  out  1  writeback data: 0 = ALUOut, 1 = MDR
- alusrca  out  1  ALU A input: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B input: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- pcsrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- aluop  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
- lsize  out  2  load/store size: 00 byte, 01 word, 10 double
- lsigned  out  1  sign-extend loaded byte
- illegal  out  1  one-cycle pulse on unrecognised opcode
- state  out  4  current state, for debug

Behaviour:
- State register:
  - Updates on the rising edge of clk.
  - reset=1 loads FETCH on the next edge.
- While reset=1, all enables are forced 0: pcwrite, irwrite, regwrite, memwrite, branch, bne and illegal.
  - Remaining outputs show FETCH values.
- Unlisted outputs are 0 in each state.
- States, outputs and transitions:
  - FETCH: iord=0, alusrca=0, alusrcb=PC_INC_SEL, aluop=000, pcsrc=00, irwrite=1, pcwrite=1. Next: DECODE.
  - DECODE: alusrca=0, alusrcb=11, aluop=000 (branch target into ALUOut). Next state by op:
    - LW/LB/LBU/LD/SW/SB/SD -> MEMADR
    - RTYPE -> RTEXE
    - ADDI/ANDI/ORI/SLTI/DADDI -> IMMEXE
    - BEQ/BNE -> BRANCH
    - J -> JUMP
    - anything else -> FETCH, with illegal=1 this cycle
  - MEMADR: alusrca=1, alusrcb=10, aluop=000. Next: MEMRD for loads, MEMWR for stores.
  - MEMRD: iord=1. Next: MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
  - MEMWR: iord=1, memwrite=1. Next: FETCH.
  - RTEXE: alusrca=1, alusrcb=00, aluop=010. Next: RTWB.
  - RTWB: regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
  - IMMEXE: alusrca=1, alusrcb=10. aluop by op: ADDI/DADDI 000, ANDI 011, ORI 100, SLTI 101. Next: IMMWB.
  - IMMWB: regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=001, pcsrc=01. branch=1 for BEQ, bne=1 for BNE. Next: FETCH.
  - JUMP: pcsrc=10, pcwrite=1. Next: FETCH.
- lsize and lsigned are decoded from op in MEMADR through MEMWB/MEMWR, and are 0 elsewhere:
  - LB: lsize=00, lsigned=1
  - LBU: lsize=00, lsigned=0
  - SB: lsize=00
  - LW/SW: lsize=01
  - LD/SD: lsize=10
- Latency in cycles, FETCH to next FETCH:
  - J 3, BEQ/BNE 3
  - RTYPE 4, immediate ops 4, stores 4
  - loads 5
  - illegal 2
- Reset asserted mid-instruction: the next state is FETCH regardless of the current state. No write enable may be asserted in the reset cycle.
- Unused state encodings go to FETCH.

Optional Feature:
- Macro: MC_MEM_WAIT_EN.
- Defined:
  - Adds the memready input.
  - FETCH, MEMRD and MEMWR hold their state until memready=1.
  - In FETCH, irwrite and pcwrite assert only in the cycle where memready=1.
  - In MEMWR, memwrite stays high for the whole wait.
  - Each wait cycle adds one cycle of latency.
- Undefined:
  - memready port is absent.
  - Every memory state lasts exactly one cycle.

Test Plan:
- Reset held 2 cycles, then released with op=000000 -> during reset state=FETCH and all enables 0; after release: FETCH, DECODE, RTEXE (aluop=010), RTWB (regdst=1, regwrite=1), FETCH.
- op=100011 (LW) -> FETCH, DECODE, MEMADR, MEMRD (iord=1), MEMWB (memtoreg=1, regwrite=1); lsize=01; 5 cycles total.
- op=000101 (BNE) -> BRANCH with bne=1, branch=0, aluop=001, pcsrc=01; op=000100 gives branch=1, bne=0.
- op=001101 (ORI), op=001010 (SLTI) -> IMMEXE aluop=100 and 101 respectively; IMMWB regdst=0, regwrite=1.
- op=111000 (undefined) -> illegal=1 for exactly the DECODE cycle, then FETCH; no write enables asserted.
- MC_MEM_WAIT_EN, op=101000 (SB), memready low 3 cycles in MEMWR -> memwrite=1 and lsize=00 for 4 cycles, then FETCH; reset asserted during the wait returns to FETCH with memwrite=0.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional MC_MEM_WAIT_EN adds memready stalls in FETCH, MEMRD and MEMWR.
module mc_controller #(
    parameter logic [1:0] PC_INC_SEL = 2'b01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
`ifdef MC_MEM_WAIT_EN
    input  logic       memready,
`endif
    output logic       pcwrite,
    output logic       branch,
    output logic       bne,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic [1:0] lsize,
    output logic       lsigned,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_IMMEXE = 4'd8,
        S_IMMWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_DADDI = 6'b011000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LD    = 6'b110111;
    localparam logic [5:0] OP_SD    = 6'b111111;

    state_e state_q, state_d, cur;
    logic   mem_rdy;
    logic   is_load, is_store, is_rt, is_imm, is_br, is_j;

`ifdef MC_MEM_WAIT_EN
    assign mem_rdy = memready;
`else
    assign mem_rdy = 1'b1;
`endif

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_rt    = 1'b0;
        is_imm   = 1'b0;
        is_br    = 1'b0;
        is_j     = 1'b0;
        case (op)
            OP_LW, OP_LB, OP_LBU, OP_LD:               is_load  = 1'b1;
            OP_SW, OP_SB, OP_SD:                       is_store = 1'b1;
            OP_RTYPE:                                  is_rt    = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_DADDI: is_imm = 1'b1;
            OP_BEQ, OP_BNE:                            is_br    = 1'b1;
            OP_J:                                      is_j     = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_load || is_store) state_d = S_MEMADR;
                else if (is_rt)          state_d = S_RTEXE;
                else if (is_imm)         state_d = S_IMMEXE;
                else if (is_br)          state_d = S_BRANCH;
                else if (is_j)           state_d = S_JUMP;
                else                     state_d = S_FETCH;
            end
            S_MEMADR: state_d = is_load ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_rdy ? S_FETCH : S_MEMWR;
            S_RTEXE:  state_d = S_RTWB;
            S_IMMEXE: state_d = S_IMMWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Under reset the outputs present FETCH with every enable suppressed.
    assign cur   = reset ? S_FETCH : state_q;
    assign state = cur;

    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        bne      = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 3'b000;
        lsize    = 2'b00;
        lsigned  = 1'b0;
        illegal  = 1'b0;
        case (cur)
            S_FETCH: begin
                alusrcb = PC_INC_SEL;
                irwrite = mem_rdy;
                pcwrite = mem_rdy;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                illegal = !(is_load || is_store || is_rt || is_imm || is_br || is_j);
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTEXE: begin
                alusrca = 1'b1;
                aluop   = 3'b010;
            end
            S_RTWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_IMMEXE: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op)
                    OP_ANDI: aluop = 3'b011;
                    OP_ORI:  aluop = 3'b100;
                    OP_SLTI: aluop = 3'b101;
                    default: aluop = 3'b000;
                endcase
            end
            S_IMMWB: regwrite = 1'b1;
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 3'b001;
                pcsrc   = 2'b01;
                branch  = (op == OP_BEQ);
                bne     = (op == OP_BNE);
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        if (cur inside {S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR}) begin
            lsigned = (op == OP_LB);
            case (op)
                OP_LW, OP_SW: lsize = 2'b01;
                OP_LD, OP_SD: lsize = 2'b10;
                default:      lsize = 2'b00;
            endcase
        end
        if (reset) begin
            pcwrite  = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            branch   = 1'b0;
            bne      = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: opcode table, randomized instruction stream
// against an instruction-level model, and reset/wait corner sequences.
module tb_mc_controller;

    typedef struct packed {
        logic [3:0] state;
        logic       pcwrite, branch, bne, iord, irwrite;
        logic       memwrite, regwrite, regdst, memtoreg, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] aluop;
        logic [1:0] lsize;
        logic       lsigned, illegal;
    } out_t;

    typedef struct {
        logic [5:0] op;
        int         cyc;
        logic [3:0] st2;
        logic [2:0] alu2;
    } vec_t;

    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
    localparam int P_RE = 6, P_RW = 7, P_IE = 8, P_IW = 9, P_BR = 10, P_J = 11;
    localparam int K_LD = 0, K_ST = 1, K_RT = 2, K_IM = 3, K_BR = 4, K_J = 5, K_IL = 6;
`ifdef MC_MEM_WAIT_EN
    localparam int MAXW = 3;
`else
    localparam int MAXW = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_r = 1'b1;
    logic [5:0] op_r = '0;
    logic       mr_r = 1'b1;
    out_t       act;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk),
        .reset(reset_r),
        .op(op_r),
`ifdef MC_MEM_WAIT_EN
        .memready(mr_r),
`endif
        .pcwrite(act.pcwrite),
        .branch(act.branch),
        .bne(act.bne),
        .iord(act.iord),
        .irwrite(act.irwrite),
        .memwrite(act.memwrite),
        .regwrite(act.regwrite),
        .regdst(act.regdst),
        .memtoreg(act.memtoreg),
        .alusrca(act.alusrca),
        .alusrcb(act.alusrcb),
        .pcsrc(act.pcsrc),
        .aluop(act.aluop),
        .lsize(act.lsize),
        .lsigned(act.lsigned),
        .illegal(act.illegal),
        .state(act.state)
    );

    function automatic int kind(logic [5:0] o);
        case (o)
            6'b100011, 6'b100000, 6'b100100, 6'b110111: return K_LD;
            6'b101011, 6'b101000, 6'b111111:            return K_ST;
            6'b000000:                                  return K_RT;
            6'b001000, 6'b001100, 6'b001101,
            6'b001010, 6'b011000:                       return K_IM;
            6'b000100, 6'b000101:                       return K_BR;
            6'b000010:                                  return K_J;
            default:                                    return K_IL;
        endcase
    endfunction

    function automatic out_t ref_out(int ph, logic [5:0] o, logic rst, logic rdy);
        out_t e;
        int   p;
        e = '0;
        p = rst ? P_F : ph;
        e.state = 4'(p);
        if (p inside {P_MA, P_MR, P_MWB, P_MW}) begin
            e.lsize   = (o == 6'b100011 || o == 6'b101011) ? 2'b01 :
                        (o == 6'b110111 || o == 6'b111111) ? 2'b10 : 2'b00;
            e.lsigned = (o == 6'b100000);
        end
        case (p)
            P_F:   begin e.alusrcb = 2'b01; e.irwrite = rdy; e.pcwrite = rdy; end
            P_D:   begin e.alusrcb = 2'b11; e.illegal = (kind(o) == K_IL); end
            P_MA:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            P_MR:  e.iord = 1;
            P_MWB: begin e.memtoreg = 1; e.regwrite = 1; end
            P_MW:  begin e.iord = 1; e.memwrite = 1; end
            P_RE:  begin e.alusrca = 1; e.aluop = 3'b010; end
            P_RW:  begin e.regdst = 1; e.regwrite = 1; end
            P_IE: begin
                e.alusrca = 1;
                e.alusrcb = 2'b10;
                e.aluop = (o == 6'b001100) ? 3'b011 :
                          (o == 6'b001101) ? 3'b100 :
                          (o == 6'b001010) ? 3'b101 : 3'b000;
            end
            P_IW:  e.regwrite = 1;
            P_BR: begin
                e.alusrca = 1;
                e.aluop = 3'b001;
                e.pcsrc = 2'b01;
                e.branch = (o == 6'b000100);
                e.bne = (o == 6'b000101);
            end
            P_J:   begin e.pcsrc = 2'b10; e.pcwrite = 1; end
            default: ;
        endcase
        if (rst) begin
            e.pcwrite = 0; e.irwrite = 0; e.regwrite = 0; e.memwrite = 0;
            e.branch = 0; e.bne = 0; e.illegal = 0;
        end
        return e;
    endfunction

    task automatic step(string nm, int ph, logic [5:0] o, logic rst, logic rdy);
        out_t e;
        op_r = o;
        reset_r = rst;
        mr_r = rdy;
        #1;
        e = ref_out(ph, o, rst, rdy);
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL %s ph=%0d op=%b rst=%b rdy=%b got=%h exp=%h",
                     nm, ph, o, rst, rdy, act, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(string nm, logic [5:0] o, int maxw);
        int q[$];
        int w;
        case (kind(o))
            K_LD:    q = '{P_F, P_D, P_MA, P_MR, P_MWB};
            K_ST:    q = '{P_F, P_D, P_MA, P_MW};
            K_RT:    q = '{P_F, P_D, P_RE, P_RW};
            K_IM:    q = '{P_F, P_D, P_IE, P_IW};
            K_BR:    q = '{P_F, P_D, P_BR};
            K_J:     q = '{P_F, P_D, P_J};
            default: q = '{P_F, P_D};
        endcase
        foreach (q[i]) begin
            w = 0;
            if (maxw > 0 && q[i] inside {P_F, P_MR, P_MW})
                w = $urandom_range(0, maxw);
            for (int k = 0; k < w; k++) step(nm, q[i], o, 1'b0, 1'b0);
            step(nm, q[i], o, 1'b0, 1'b1);
        end
    endtask

    task automatic run_vec(vec_t v);
        op_r = v.op;
        reset_r = 1'b0;
        mr_r = 1'b1;
        for (int i = 0; i < v.cyc; i++) begin
            if (i == 2) begin
                #1;
                vectors++;
                if (act.state !== v.st2 || act.aluop !== v.alu2) begin
                    miscompares++;
                    $display("FAIL vec_exec op=%b got st=%0d alu=%b exp st=%0d alu=%b",
                             v.op, act.state, act.aluop, v.st2, v.alu2);
                end
            end
            @(posedge clk);
            #1;
        end
        #1;
        vectors++;
        if (act.state !== 4'd0) begin
            miscompares++;
            $display("FAIL vec_latency op=%b cyc=%0d got st=%0d exp st=0",
                     v.op, v.cyc, act.state);
        end
    endtask

    vec_t vt[16];
    logic [5:0] pool[15];

    initial begin
        vt[0]  = '{6'b000000, 4, 4'd6,  3'b010};
        vt[1]  = '{6'b100011, 5, 4'd2,  3'b000};
        vt[2]  = '{6'b100000, 5, 4'd2,  3'b000};
        vt[3]  = '{6'b100100, 5, 4'd2,  3'b000};
        vt[4]  = '{6'b110111, 5, 4'd2,  3'b000};
        vt[5]  = '{6'b101011, 4, 4'd2,  3'b000};
        vt[6]  = '{6'b101000, 4, 4'd2,  3'b000};
        vt[7]  = '{6'b111111, 4, 4'd2,  3'b000};
        vt[8]  = '{6'b001000, 4, 4'd8,  3'b000};
        vt[9]  = '{6'b001100, 4, 4'd8,  3'b011};
        vt[10] = '{6'b001101, 4, 4'd8,  3'b100};
        vt[11] = '{6'b001010, 4, 4'd8,  3'b101};
        vt[12] = '{6'b011000, 4, 4'd8,  3'b000};
        vt[13] = '{6'b000100, 3, 4'd10, 3'b001};
        vt[14] = '{6'b000101, 3, 4'd10, 3'b001};
        vt[15] = '{6'b111000, 2, 4'd0,  3'b000};
        for (int i = 0; i < 15; i++) pool[i] = vt[i].op;
        pool[14] = 6'b000010;

        @(posedge clk);
        #1;
        step("reset0", P_F, 6'b000000, 1'b1, 1'b1);
        step("reset1", P_F, 6'b000000, 1'b1, 1'b1);
        run_instr("rtype", 6'b000000, 0);
        run_instr("lw", 6'b100011, 0);
        run_instr("bne", 6'b000101, 0);
        run_instr("beq", 6'b000100, 0);
        run_instr("ori", 6'b001101, 0);
        run_instr("slti", 6'b001010, 0);
        run_instr("undef", 6'b111000, 0);
        run_instr("j", 6'b000010, 0);

        for (int i = 0; i < 16; i++) run_vec(vt[i]);

        for (int n = 0; n < 80; n++) begin
            logic [5:0] o;
            if ($urandom_range(0, 4) == 0) o = 6'($urandom);
            else o = pool[$urandom_range(0, 14)];
            run_instr("rand", o, MAXW);
        end

        step("mid_f", P_F, 6'b100011, 1'b0, 1'b1);
        step("mid_d", P_D, 6'b100011, 1'b0, 1'b1);
        step("mid_ma", P_MA, 6'b100011, 1'b0, 1'b1);
        step("mid_rst_mr", P_MR, 6'b100011, 1'b1, 1'b1);
        step("mid_f2", P_F, 6'b000000, 1'b0, 1'b1);
        step("mid_d2", P_D, 6'b000000, 1'b0, 1'b1);
        step("mid_re", P_RE, 6'b000000, 1'b0, 1'b1);
        step("mid_rst_rw", P_RW, 6'b000000, 1'b1, 1'b1);
        step("mid_f3", P_F, 6'b101011, 1'b0, 1'b1);
        step("mid_d3", P_D, 6'b101011, 1'b0, 1'b1);
        step("mid_ma3", P_MA, 6'b101011, 1'b0, 1'b1);
        step("mid_rst_mw", P_MW, 6'b101011, 1'b1, 1'b1);
        run_instr("post_rst", 6'b001100, 0);

`ifdef MC_MEM_WAIT_EN
        step("sb_f", P_F, 6'b101000, 1'b0, 1'b1);
        step("sb_d", P_D, 6'b101000, 1'b0, 1'b1);
        step("sb_ma", P_MA, 6'b101000, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step("sb_wait", P_MW, 6'b101000, 1'b0, 1'b0);
        step("sb_done", P_MW, 6'b101000, 1'b0, 1'b1);
        step("sb_f2", P_F, 6'b101000, 1'b0, 1'b1);
        step("sb_d2", P_D, 6'b101000, 1'b0, 1'b1);
        step("sb_ma2", P_MA, 6'b101000, 1'b0, 1'b1);
        step("sb_wait2", P_MW, 6'b101000, 1'b0, 1'b0);
        step("sb_rst", P_MW, 6'b101000, 1'b1, 1'b0);
        step("fetch_wait", P_F, 6'b100011, 1'b0, 1'b0);
        step("fetch_go", P_F, 6'b100011, 1'b0, 1'b1);
        step("lw_d", P_D, 6'b100011, 1'b0, 1'b1);
        step("lw_ma", P_MA, 6'b100011, 1'b0, 1'b1);
        step("lw_mr_wait", P_MR, 6'b100011, 1'b0, 1'b0);
        step("lw_mr", P_MR, 6'b100011, 1'b0, 1'b1);
        step("lw_wb", P_MWB, 6'b100011, 1'b0, 1'b1);
`endif
        run_instr("final", 6'b000010, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
